// File: rtl/cern_vme_master_if.sv
// Bus bundle for the VME-style register master: the host request/response
// channel plus the strobe/done register bus towards the slave maps.
// The master modport is the initiator's view and the slave modport is the mirror view.
interface cern_vme_master_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    // host request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // host response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [7:0]            err_count;

    // register bus towards the slave maps
    logic [ADDR_WIDTH-1:0] VMEAddr;
    logic [DATA_WIDTH-1:0] VMEWrData;
    logic                  VMERdMem;
    logic                  VMEWrMem;
    logic [DATA_WIDTH-1:0] VMERdData;
    logic                  VMERdDone;
    logic                  VMEWrDone;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
               VMERdData, VMERdDone, VMEWrDone,
        output req_ready, resp_valid, resp_rdata, resp_err, err_count,
               VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
               VMERdData, VMERdDone, VMEWrDone,
        input  req_ready, resp_valid, resp_rdata, resp_err, err_count,
               VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );
endinterface

// File: rtl/cern_vme_master.sv
// Single-outstanding initiator for the strobe/done register bus.
// A host request becomes a one-cycle read or write strobe. Address and write data
// stay on the bus until the matching done pulse arrives. The result, or a timeout
// error, is then offered on the response channel until the host takes it.
module cern_vme_master #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255   // WAIT cycles before giving up, 1..65535
) (
    input  logic Clk,
    input  logic rst_n,
    cern_vme_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int CNT_W = 16;
    // The counter is compared against TIMEOUT-1 so that the last WAIT cycle
    // without a done is the TIMEOUT-th one.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    // Word-aligned bus: the two byte-lane bits are never driven.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t           state;
    state_t           state_nxt;
    logic             we_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             done_hit;
    logic             timeout_hit;

    // Saturating increment for the 8-bit error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only the done that matches the operation in flight counts.
    assign done_hit    = we_q ? bus.VMEWrDone : bus.VMERdDone;
    assign timeout_hit = (wait_cnt == TO_LAST);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: done beats timeout when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = STROBE;
            STROBE:  state_nxt = WAIT;
            WAIT:    if (done_hit || timeout_hit) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded from the current state.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.VMERdMem   = 1'b0;
        bus.VMEWrMem   = 1'b0;
        case (state)
            IDLE:    bus.req_ready  = 1'b1;
            STROBE: begin
                bus.VMERdMem = ~we_q;
                bus.VMEWrMem = we_q;
            end
            RESP:    bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture the accepted request onto the bus; values persist through IDLE.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            we_q          <= 1'b0;
            bus.VMEAddr   <= '0;
            bus.VMEWrData <= '0;
        end else if (state == IDLE && bus.req_valid) begin
            we_q        <= bus.req_we;
            bus.VMEAddr <= bus.req_addr & ADDR_MASK;
            if (bus.req_we) begin
                bus.VMEWrData <= bus.req_wdata;
            end
        end
    end

    // Timeout counter: cleared in the strobe cycle and advanced on each idle WAIT cycle.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == STROBE) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !done_hit && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Response capture and error accounting, updated only when WAIT resolves.
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.err_count  <= '0;
        end else if (state == WAIT) begin
            if (done_hit) begin
                bus.resp_rdata <= we_q ? '0 : bus.VMERdData;
                bus.resp_err   <= 1'b0;
            end else if (timeout_hit) begin
                bus.resp_rdata <= '0;
                bus.resp_err   <= 1'b1;
                bus.err_count  <= sat_inc8(bus.err_count);
            end
        end
    end

endmodule

// File: tb/tb_cern_vme_master.sv
// Bench for cern_vme_master: acts as host and as slave. Expected cycle timing,
// data and error counts are derived per transaction from the access rules.
module tb_cern_vme_master;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int TO = 8;

    logic Clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 Clk = ~Clk;

    cern_vme_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cern_vme_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference state: what the bus and counters should show
    logic [AW-1:0] model_addr  = '0;
    logic [DW-1:0] model_wdata = '0;
    int            model_errcnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_slave();
        bus.VMERdDone = 1'b0;
        bus.VMEWrDone = 1'b0;
        bus.VMERdData = DW'($urandom);
    endtask

    // One host access. k = cycles from strobe to done (k > TO means no done).
    // hold = extra RESP cycles with resp_ready low, stray = wrong/early dones,
    // late = a matching done pulse delivered after the transaction finished.
    task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int k, input logic [DW-1:0] sdata, input int hold,
                           input bit stray, input bit late);
        bit            tmo;
        int            rc;
        logic [DW-1:0] exp_rdata;
        tmo       = (k > TO);
        rc        = tmo ? TO + 1 : k + 1;
        exp_rdata = (!tmo && !we) ? sdata : '0;
        if (tmo) model_errcnt = (model_errcnt < 255) ? model_errcnt + 1 : 255;

        // cycle T: present the request
        @(negedge Clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        model_addr    = {addr[AW-1:2], 2'b00};
        if (we) model_wdata = wdata;

        // cycle T+1: strobe
        @(negedge Clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        check("strobe_rd", bus.VMERdMem, !we);
        check("strobe_wr", bus.VMEWrMem, we);
        check("strobe_resp_valid", bus.resp_valid, 0);
        check("strobe_req_ready", bus.req_ready, 0);
        check("strobe_addr", bus.VMEAddr, model_addr);
        check("strobe_wdata", bus.VMEWrData, model_wdata);
        clear_slave();
        if (stray) begin
            if (we) bus.VMEWrDone = 1'b1;
            else    bus.VMERdDone = 1'b1;
        end

        // cycles T+2 ..: wait for done / timeout
        for (int c = 1; c <= rc; c++) begin
            @(negedge Clk);
            check("wait_resp_valid", bus.resp_valid, (c == rc));
            check("wait_rd_strobe", bus.VMERdMem, 0);
            check("wait_wr_strobe", bus.VMEWrMem, 0);
            check("wait_req_ready", bus.req_ready, 0);
            check("wait_addr", bus.VMEAddr, model_addr);
            check("wait_wdata", bus.VMEWrData, model_wdata);
            clear_slave();
            if (c < rc) begin
                if (!tmo && c == k) begin
                    if (we) bus.VMEWrDone = 1'b1;
                    else begin
                        bus.VMERdDone = 1'b1;
                        bus.VMERdData = sdata;
                    end
                end else if (stray) begin
                    if (we) bus.VMERdDone = 1'b1;
                    else    bus.VMEWrDone = 1'b1;
                end
            end
        end

        // first RESP cycle
        check("resp_rdata", bus.resp_rdata, exp_rdata);
        check("resp_err", bus.resp_err, tmo);
        check("err_count", bus.err_count, model_errcnt);
        bus.resp_ready = (hold == 0);
        if (hold > 0) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'($urandom);
            bus.req_addr  = AW'($urandom);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            check("hold_resp_valid", bus.resp_valid, 1);
            check("hold_rdata", bus.resp_rdata, exp_rdata);
            check("hold_err", bus.resp_err, tmo);
            check("hold_req_ready", bus.req_ready, 0);
            if (h == hold - 1) begin
                bus.resp_ready = 1'b1;
                bus.req_valid  = 1'b0;
            end
        end

        // back in IDLE
        @(negedge Clk);
        bus.resp_ready = 1'b0;
        check("idle_resp_valid", bus.resp_valid, 0);
        check("idle_req_ready", bus.req_ready, 1);

        if (late) begin
            @(negedge Clk);
            if (we) bus.VMEWrDone = 1'b1;
            else    bus.VMERdDone = 1'b1;
            @(negedge Clk);
            clear_slave();
            check("late_resp_valid", bus.resp_valid, 0);
            check("late_req_ready", bus.req_ready, 1);
            check("late_err_count", bus.err_count, model_errcnt);
        end
    endtask

    // Start a read, then pull reset while the master is waiting for done.
    task automatic reset_in_wait();
        @(negedge Clk);
        check("rst_req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'($urandom);
        @(negedge Clk);
        bus.req_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        rst_n = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
        model_addr   = '0;
        model_wdata  = '0;
        model_errcnt = 0;
        check("rst_rd_strobe", bus.VMERdMem, 0);
        check("rst_wr_strobe", bus.VMEWrMem, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_err_count", bus.err_count, 0);
        check("rst_addr", bus.VMEAddr, 0);
        // a done for the abandoned read must not produce anything
        bus.VMERdDone = 1'b1;
        @(negedge Clk);
        clear_slave();
        check("rst_stale_done", bus.resp_valid, 0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        bus.VMERdData  = '0;
        bus.VMERdDone  = 1'b0;
        bus.VMEWrDone  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_resp_valid", bus.resp_valid, 0);
        check("reset_rd_strobe", bus.VMERdMem, 0);
        check("reset_wr_strobe", bus.VMEWrMem, 0);
        check("reset_err_count", bus.err_count, 0);
        check("reset_addr", bus.VMEAddr, 0);
        check("reset_wdata", bus.VMEWrData, 0);
        check("reset_rdata", bus.resp_rdata, 0);
        check("reset_err", bus.resp_err, 0);
        rst_n = 1'b1;

        // directed scenarios
        run_txn(1'b0, 20'h00100, 32'h0, 1, 32'h12345678, 0, 1'b0, 1'b0);
        run_txn(1'b1, 20'h00004, 32'hCAFEF00D, 5, 32'h0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 20'h00200, 32'h0, TO + 4, 32'hDEADBEEF, 0, 1'b0, 1'b1);
        run_txn(1'b0, 20'h00300, 32'h0, 3, 32'hA5A5_0F0F, 4, 1'b0, 1'b0);
        run_txn(1'b0, 20'h00007, 32'h0, 4, 32'h1357_9BDF, 0, 1'b1, 1'b0);
        run_txn(1'b0, 20'h00010, 32'h0, TO, 32'h0BAD_CAFE, 0, 1'b0, 1'b0);
        run_txn(1'b1, 20'h00013, 32'h7777_1111, TO + 1, 32'h0, 2, 1'b1, 1'b1);

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom),
                    int'($urandom_range(1, TO + 3)), DW'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        // drive the error counter into saturation
        for (int i = 0; i < 260; i++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), TO + 1, DW'($urandom), 0, 1'b0, 1'b0);
        end
        check("err_count_saturated", bus.err_count, 255);

        reset_in_wait();
        run_txn(1'b0, 20'h00040, 32'h0, 2, 32'h0F1E_2D3C, 0, 1'b0, 1'b0);
        run_txn(1'b1, 20'h00044, 32'h4B5A_6978, 1, 32'h0, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard bound on run time
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "time limit");
    end
endmodule
